spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
- SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drains the TX FIFO of the APB/FIFO bridge and fills its RX FIFO.
- Each TX word is one SPI frame of FRAME_BITS bits. The received frame is zero-extended and pushed into the RX FIFO.
- Sits directly downstream of the APB/FIFO bridge and drives the external SPI pins.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must match the bridge.
- FRAME_BITS, 8, bits per SPI frame; legal range 1..DATA_WIDTH; taken from fifo_r_data_tx[FRAME_BITS-1:0].
- CLK_DIV, 2, pclk cycles per SCLK half-period; minimum 1; SCLK = pclk/(2*CLK_DIV).

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset, synchronous, active low.
- en  in  1  engine enable; sampled only in IDLE.
- read_fifo_tx  out  1  one-cycle pop strobe to the TX FIFO.
- empty_tx  in  1  TX FIFO empty.
- fifo_r_data_tx  in  DATA_WIDTH  TX FIFO head word; first-word-fall-through, valid while !empty_tx.
- write_fifo_rx  out  1  one-cycle push strobe to the RX FIFO.
- full_rx  in  1  RX FIFO full.
- fifo_w_data_rx  out  DATA_WIDTH  RX push data; upper DATA_WIDTH-FRAME_BITS bits are 0.
- sclk  out  1  SPI clock, idles low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, pclk. presetn is synchronous and active low.
- Reset values (any time presetn=0, effective at the next pclk edge): state=IDLE, cs_n=1, sclk=0, mosi=0, read_fifo_tx=0, write_fifo_rx=0, fifo_w_data_rx=0, busy=0, all counters 0.
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE:
  - If en & !empty_tx & !full_rx: read_fifo_tx=1 combinationally for that cycle; fifo_r_data_tx[FRAME_BITS-1:0] is captured into tx_shift; next state SETUP.
  - Otherwise stay in IDLE, with no pop.
  - full_rx is checked before the pop so that the frame's RX slot is guaranteed free.
- SETUP:
  - Lasts CLK_DIV cycles.
  - cs_n=0, sclk=0, mosi=tx_shift[FRAME_BITS-1].
- SHIFT:
  - 2*FRAME_BITS half-periods of CLK_DIV cycles each, counted by half_cnt.
  - The first half-period has sclk=1; sclk toggles at each half-period boundary.
  - On the pclk edge that drives sclk 0→1: rx_shift <= {rx_shift[FRAME_BITS-2:0], miso}.
  - On the edge that drives sclk 1→0, except the last: tx_shift shifts left and mosi presents the next bit.
  - After the final half-period, sclk returns to 0 and the next state is DONE.
- DONE:
  - Lasts 1 cycle, with cs_n=0.
  - write_fifo_rx=1 and fifo_w_data_rx = zero-extended rx_shift.
  - Next state GAP.
- GAP:
  - Lasts CLK_DIV cycles, with cs_n=1 and mosi=0.
  - Next state IDLE.
- Frame latency:
  - Pop cycle T0; cs_n falls at T0+1; first sclk rise at T0+1+CLK_DIV.
  - RX push at T0+1+CLK_DIV+2*FRAME_BITS*CLK_DIV.
  - Next pop no earlier than the push cycle + CLK_DIV + 1.
- Edge cases:
  - en deasserted mid-frame: the frame completes normally; no new pop.
  - Reset mid-frame: the popped word is discarded and no RX push occurs.
  - A pop and a push never occur in the same cycle.
- Widths:
  - div_cnt is $clog2(CLK_DIV+1) bits.
  - half_cnt is $clog2(2*FRAME_BITS+1) bits.
  - Counters reload to 0 on every state entry. No wrap-around beyond terminal count.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum {IDLE, SETUP, SHIFT, DONE, GAP}.
  - Constants SPI_CPOL=0 and SPI_CPHA=0.
- One sub-module, spi_tick_gen:
  - Free-runs while its enable is high and pulses tick every CLK_DIV cycles.
  - Restarts at 0 when enable rises.
  - Used for the SETUP, SHIFT and GAP timing.

Test Plan:
1. CLK_DIV=2, FRAME_BITS=8, TX word 0x000000A5, miso tied to mosi:
   - mosi at the rising edges is 1,0,1,0,0,1,0,1.
   - cs_n is low for exactly 35 cycles (T0+1..T0+35).
   - write_fifo_rx pulses at T0+35 with 0x000000A5.
2. empty_tx=1 for 100 cycles with en=1 -> read_fifo_tx never asserts; cs_n=1 and sclk=0 throughout; busy=0.
3. empty_tx=0, full_rx=1 for 20 cycles, then 0 -> no pop while full; pop occurs in the first cycle full_rx=0.
4. Words 0x01, 0x80, 0xFF queued, miso=1:
   - Exactly 3 pops and 3 frames, each followed by a 2-cycle cs_n-high gap.
   - RX pushes 0x000000FF three times.
   - mosi frame 2 is 1 then seven 0s.
5. presetn=0 for 1 cycle after the 4th sclk rise of a frame -> next cycle cs_n=1, sclk=0, busy=0; no write_fifo_rx for that frame.
6. en dropped during SHIFT of frame 1 with 2 words queued -> frame 1 completes and pushes; no second pop until en returns.

Source files
------------

// File: rtl/spi_master_engine_pkg.sv
// Shared types and constants for the SPI master engine.
package spi_pkg;

    // Engine states: IDLE waits for work, SETUP asserts cs_n ahead of the first
    // edge, SHIFT clocks the frame, DONE pushes RX, GAP holds cs_n high.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_engine_if.sv
// FIFO handshake and SPI pin bundle between the engine and its neighbours.
interface spi_master_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  read_fifo_tx;
    logic                  empty_tx;
    logic [DATA_WIDTH-1:0] fifo_r_data_tx;
    logic                  write_fifo_rx;
    logic                  full_rx;
    logic [DATA_WIDTH-1:0] fifo_w_data_rx;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    // Engine side: pops TX, pushes RX, drives the SPI pins.
    modport master (
        output read_fifo_tx, write_fifo_rx, fifo_w_data_rx, sclk, mosi, cs_n,
        input  empty_tx, fifo_r_data_tx, full_rx, miso
    );

    // FIFO / SPI device side.
    modport slave (
        input  read_fifo_tx, write_fifo_rx, fifo_w_data_rx, sclk, mosi, cs_n,
        output empty_tx, fifo_r_data_tx, full_rx, miso
    );
endinterface

// File: rtl/spi_master_engine_tick_gen.sv
// Divider that pulses tick every CLK_DIV cycles while enabled. The count is
// held at 0 while disabled, so every enable rise starts a fresh period.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Next count and tick pulse; wraps to 0 exactly on the tick.
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            tick      = 1'b1;
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 SPI master: pops one TX FIFO word per frame, shifts FRAME_BITS bits
// MSB first and pushes the zero-extended received frame into the RX FIFO.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_BITS = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 en,
    output logic                 busy,
    spi_master_engine_if.master  bus
);
    localparam int HALF_W = $clog2(2 * FRAME_BITS + 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

    spi_state_t              state_q, state_d;
    logic [HALF_W-1:0]       half_cnt_q, half_cnt_d;
    logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_n_q, cs_n_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    tick;
    logic                    tick_en;
    logic                    start;
    logic                    sclk_rise;
    logic                    sclk_fall;

    // Pop only when the RX slot for this frame is already known to be free.
    assign start   = (state_q == IDLE) && en && !bus.empty_tx && !bus.full_rx;
    assign tick_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == GAP);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (tick_en),
        .tick    (tick)
    );

    // State, counter, shift and pin registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            sclk_q     <= SPI_CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            write_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next state and half-period counter; counter restarts on every state entry.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETUP;
                    half_cnt_d = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d    = SHIFT;
                    half_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (half_cnt_q == HALF_LAST) begin
                        state_d    = DONE;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = GAP;
                half_cnt_d = '0;
            end
            GAP: begin
                if (tick) begin
                    state_d    = IDLE;
                    half_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                half_cnt_d = '0;
            end
        endcase
    end

    // Pin and datapath values for the next cycle, derived from the next state so
    // that sclk/mosi/cs_n/write leave the engine registered.
    always_comb begin
        sclk_d = SPI_CPOL;
        if ((state_d == SHIFT) && !half_cnt_d[0]) begin
            sclk_d = ~SPI_CPOL;
        end

        sclk_rise = sclk_d && !sclk_q;
        // The fall into the final half-period leaves the last bit on mosi.
        sclk_fall = !sclk_d && sclk_q && (state_d == SHIFT) && (half_cnt_d != HALF_LAST);

        tx_shift_d = tx_shift_q;
        if (start) begin
            tx_shift_d = bus.fifo_r_data_tx[FRAME_BITS-1:0];
        end else if (sclk_fall) begin
            tx_shift_d = tx_shift_q << 1;
        end

        rx_shift_d = rx_shift_q;
        if (sclk_rise) begin
            rx_shift_d    = rx_shift_q << 1;
            rx_shift_d[0] = bus.miso;
        end

        mosi_d = 1'b0;
        if ((state_d == SETUP) || (state_d == SHIFT)) begin
            mosi_d = tx_shift_d[FRAME_BITS-1];
        end

        cs_n_d  = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == DONE));
        write_d = (state_d == DONE);

        wdata_d = wdata_q;
        if (state_d == DONE) begin
            wdata_d                 = '0;
            wdata_d[FRAME_BITS-1:0] = rx_shift_q;
        end
    end

    assign bus.read_fifo_tx   = start;
    assign bus.write_fifo_rx  = write_q;
    assign bus.fifo_w_data_rx = wdata_q;
    assign bus.sclk           = sclk_q;
    assign bus.mosi           = mosi_q;
    assign bus.cs_n           = cs_n_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine (DATA_WIDTH=32, FRAME_BITS=8, CLK_DIV=2).
module tb_spi_master_engine;

    logic pclk = 1'b0;
    logic presetn;
    logic en;
    logic busy;
    logic miso_tie;
    logic miso_val;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int pops = 0;
    int pushes = 0;
    int rises = 0;
    int low_len = 0;
    int last_push_cyc = -1;
    int last_pop_cyc = -1;
    int idle_viol = 0;
    bit chk_cs = 1'b0;
    bit chk_spacing = 1'b0;
    bit idle_watch = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_cs_n = 1'b1;
    logic fifo_pop;

    logic [31:0] txq[$];
    logic [31:0] exp_rx[$];
    int          pop_cyc_q[$];
    logic        mosi_log[$];

    spi_master_engine_if #(.DATA_WIDTH(32)) bus ();

    spi_master_engine #(
        .DATA_WIDTH (32),
        .FRAME_BITS (8),
        .CLK_DIV    (2)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (en),
        .busy    (busy),
        .bus     (bus)
    );

    assign bus.miso = miso_tie ? bus.mosi : miso_val;

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge pclk);
            #2;
        end
    endtask

    task automatic wait_pushes(input int target, input int budget, input string name);
        int k = 0;
        while (pushes < target && k < budget) begin
            tick_n(1);
            k++;
        end
        check(name, pushes, target);
    endtask

    function automatic logic [7:0] mosi_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            if (base + i < mosi_log.size()) b[7-i] = mosi_log[base+i];
            else b[7-i] = 1'bx;
        end
        return b;
    endfunction

    // TX FIFO model: first-word-fall-through head, popped on read_fifo_tx.
    initial begin
        bus.empty_tx       = 1'b1;
        bus.fifo_r_data_tx = '0;
        forever begin
            @(negedge pclk);
            fifo_pop = bus.read_fifo_tx;
            @(posedge pclk);
            #1;
            if (fifo_pop && txq.size() > 0) void'(txq.pop_front());
            bus.empty_tx       = (txq.size() == 0);
            bus.fifo_r_data_tx = (txq.size() > 0) ? txq[0] : 32'h0;
        end
    end

    // Monitor: pops expected RX words and frame timing on every DUT event.
    initial begin
        forever begin
            @(negedge pclk);
            cyc++;
            if (bus.read_fifo_tx) begin
                pops++;
                last_pop_cyc = cyc;
                pop_cyc_q.push_back(cyc);
                if (chk_spacing && last_push_cyc >= 0)
                    check("pop_spacing", cyc - last_push_cyc, 3);
            end
            if (bus.read_fifo_tx || bus.write_fifo_rx)
                check("pop_push_excl", {31'b0, bus.read_fifo_tx & bus.write_fifo_rx}, 0);
            if (bus.write_fifo_rx) begin
                pushes++;
                if (exp_rx.size() == 0) check("unexpected_push", bus.fifo_w_data_rx, 32'hxxxxxxxx);
                else check("rx_data", bus.fifo_w_data_rx, exp_rx.pop_front());
                if (pop_cyc_q.size() > 0) check("pop_to_push", cyc - pop_cyc_q.pop_front(), 35);
                last_push_cyc = cyc;
            end
            if (bus.sclk && !prev_sclk) begin
                rises++;
                mosi_log.push_back(bus.mosi);
            end
            if (!bus.cs_n) begin
                low_len++;
            end else begin
                if (!prev_cs_n && chk_cs) check("cs_low_len", low_len, 35);
                low_len = 0;
            end
            if (idle_watch && (bus.read_fifo_tx || !bus.cs_n || bus.sclk || busy)) idle_viol++;
            prev_sclk = bus.sclk;
            prev_cs_n = bus.cs_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus; expected RX words go into exp_rx as each frame is queued.
    initial begin
        int p0;
        int q0;
        int r0;
        int k;
        int exp_pop;

        presetn     = 1'b0;
        en          = 1'b0;
        miso_tie    = 1'b1;
        miso_val    = 1'b0;
        bus.full_rx = 1'b0;
        tick_n(3);
        @(negedge pclk);
        #1;
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_pop", bus.read_fifo_tx, 0);
        check("rst_push", bus.write_fifo_rx, 0);
        check("rst_wdata", bus.fifo_w_data_rx, 0);
        check("rst_busy", busy, 0);
        tick_n(1);
        presetn = 1'b1;
        tick_n(2);

        // Loopback frame 0xA5.
        txq.push_back(32'h000000A5);
        exp_rx.push_back(32'h000000A5);
        mosi_log.delete();
        chk_cs = 1'b1;
        en     = 1'b1;
        wait_pushes(1, 100, "t1_push");
        check("t1_mosi", {24'b0, mosi_byte(0)}, 32'hA5);
        check("t1_rises", mosi_log.size(), 8);

        // Empty TX FIFO: engine must stay quiet.
        tick_n(5);
        idle_viol  = 0;
        idle_watch = 1'b1;
        tick_n(100);
        idle_watch = 1'b0;
        check("t2_idle_quiet", idle_viol, 0);
        check("t2_no_pop", pops, 1);

        // RX full blocks the pop; pop lands in the first cycle full_rx is low.
        bus.full_rx = 1'b1;
        txq.push_back(32'h0000003C);
        exp_rx.push_back(32'h0000003C);
        p0 = pops;
        tick_n(20);
        check("t3_no_pop_full", pops, p0);
        bus.full_rx = 1'b0;
        exp_pop = cyc + 1;
        wait_pushes(2, 100, "t3_push");
        check("t3_pop_cycle", last_pop_cyc, exp_pop);

        // Three back-to-back frames with miso held high.
        tick_n(5);
        miso_tie      = 1'b0;
        miso_val      = 1'b1;
        last_push_cyc = -1;
        chk_spacing   = 1'b1;
        mosi_log.delete();
        p0 = pops;
        txq.push_back(32'h01);
        txq.push_back(32'h80);
        txq.push_back(32'hFF);
        repeat (3) exp_rx.push_back(32'h000000FF);
        wait_pushes(5, 400, "t4_push");
        chk_spacing = 1'b0;
        check("t4_pops", pops - p0, 3);
        check("t4_mosi_f1", {24'b0, mosi_byte(0)}, 32'h01);
        check("t4_mosi_f2", {24'b0, mosi_byte(8)}, 32'h80);
        check("t4_mosi_f3", {24'b0, mosi_byte(16)}, 32'hFF);

        // Reset after the 4th rising edge aborts the frame without a push.
        tick_n(5);
        miso_tie = 1'b1;
        chk_cs   = 1'b0;
        txq.push_back(32'h5A);
        r0 = rises;
        k  = 0;
        while (rises < r0 + 4 && k < 200) begin
            tick_n(1);
            k++;
        end
        check("t5_fourth_rise", rises, r0 + 4);
        presetn = 1'b0;
        tick_n(1);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        check("t5_cs_n", bus.cs_n, 1);
        check("t5_sclk", bus.sclk, 0);
        check("t5_busy", busy, 0);
        q0 = pushes;
        pop_cyc_q.delete();
        tick_n(60);
        check("t5_no_push", pushes, q0);
        chk_cs = 1'b1;

        // en dropped mid-frame: frame finishes, next pop waits for en.
        p0 = pops;
        q0 = pushes;
        txq.push_back(32'h3C);
        txq.push_back(32'hC3);
        exp_rx.push_back(32'h0000003C);
        r0 = rises;
        k  = 0;
        while (rises < r0 + 1 && k < 100) begin
            tick_n(1);
            k++;
        end
        en = 1'b0;
        wait_pushes(q0 + 1, 100, "t6_push1");
        tick_n(60);
        check("t6_no_second_pop", pops, p0 + 1);
        exp_rx.push_back(32'h000000C3);
        en = 1'b1;
        wait_pushes(q0 + 2, 100, "t6_push2");
        check("t6_pops", pops, p0 + 2);

        tick_n(5);
        check("sb_drained", exp_rx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
